// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: states, opcodes and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_EXECUTE = 5'd6,
    S_ALUWB   = 5'd7,
    S_BRANCH  = 5'd8,
    S_BRANCHN = 5'd9,
    S_IMMEX   = 5'd10,
    S_LOGEX   = 5'd11,
    S_IMMWB   = 5'd12,
    S_JUMP    = 5'd13,
    S_JAL     = 5'd14,
    S_TRAP    = 5'd15,
    S_ERR     = 5'd16
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath, with memory ready/timeout handshake,
// illegal-opcode trap and a sticky bus-error state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int MEM_WAIT_EN = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            pcwrite,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regwrite,
  output logic            alusrca,
  output logic            branch,
  output logic            bne,
  output logic            iord,
  output logic            extop,
  output logic            memreq,
  output logic [1:0]      regdst,
  output logic [1:0]      memtoreg,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [2:0]      aluop,
  output logic            illegal,
  output logic            bus_err,
  output logic [4:0]      state
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           state_q, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             rdy;
  logic             timeout;

  assign rdy     = (MEM_WAIT_EN == 0) || mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && !rdy && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign state   = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_next;
      // Any state change or completed access restarts the wait budget.
      if (rdy || (state_next != state_q))
        wait_cnt <= '0;
      else if (is_mem_state(state_q))
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH: begin
        if (rdy)          state_next = S_DECODE;
        else if (timeout) state_next = S_ERR;
      end
      S_DECODE: begin
        case (op)
          OP_W'(OP_LW), OP_W'(OP_SW):     state_next = S_MEMADR;
          OP_W'(OP_R):                    state_next = S_EXECUTE;
          OP_W'(OP_BEQ):                  state_next = S_BRANCH;
          OP_W'(OP_BNE):                  state_next = S_BRANCHN;
          OP_W'(OP_ADDI), OP_W'(OP_SLTI): state_next = S_IMMEX;
          OP_W'(OP_ANDI), OP_W'(OP_ORI):  state_next = S_LOGEX;
          OP_W'(OP_J):                    state_next = S_JUMP;
          OP_W'(OP_JAL):                  state_next = S_JAL;
          default:                        state_next = S_TRAP;
        endcase
      end
      S_MEMADR: state_next = (op == OP_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (rdy)          state_next = S_MEMWB;
        else if (timeout) state_next = S_ERR;
      end
      S_MEMWR: begin
        if (rdy)          state_next = S_FETCH;
        else if (timeout) state_next = S_ERR;
      end
      S_EXECUTE:                 state_next = S_ALUWB;
      S_IMMEX, S_LOGEX:          state_next = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB,
      S_BRANCH, S_BRANCHN,
      S_JUMP, S_JAL, S_TRAP:     state_next = S_FETCH;
      S_ERR:                     state_next = S_ERR;
      default:                   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    iord     = 1'b0;
    extop    = 1'b0;
    memreq   = 1'b0;
    regdst   = RD_RT;
    memtoreg = M2R_ALU;
    alusrcb  = SRCB_B;
    pcsrc    = PC_ALU;
    aluop    = ALU_ADD;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memreq  = 1'b1;
        alusrcb = SRCB_4;
        irwrite = rdy;
        pcwrite = rdy;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = M2R_MEM;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        iord     = 1'b1;
        memwrite = rdy;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = RD_RD;
      end
      S_BRANCH, S_BRANCHN: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
        bne     = (state_q == S_BRANCHN);
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = (op == OP_W'(OP_SLTI)) ? ALU_SLT : ALU_ADD;
      end
      S_LOGEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        extop   = 1'b1;
        aluop   = (op == OP_W'(OP_ORI)) ? ALU_OR : ALU_AND;
      end
      S_IMMWB: regwrite = 1'b1;
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = PC_JUMP;
      end
      S_JAL: begin
        pcwrite  = 1'b1;
        pcsrc    = PC_JUMP;
        regwrite = 1'b1;
        regdst   = RD_RA;
        memtoreg = M2R_PC;
      end
      S_TRAP:  illegal = 1'b1;
      S_ERR:   bus_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios then random instruction streams against an instruction-level model.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = '0;
  logic mem_ready = 1'b0;
  logic pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord, extop, memreq;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic [2:0] aluop;
  logic illegal, bus_err;
  logic [4:0] state;

  always #5 clk = ~clk;

  mc_control_fsm #(.OP_W(6), .MEM_WAIT_EN(1), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .branch(branch), .bne(bne), .iord(iord), .extop(extop),
    .memreq(memreq), .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  typedef struct packed {
    logic pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord, extop, memreq;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] aluop;
    logic illegal, bus_err;
  } ctl_t;

  typedef enum {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_EX, T_AWB, T_BR, T_BRN,
                T_IE, T_LE, T_IWB, T_J, T_JAL, T_TRAP, T_ERR} step_t;

  ctl_t obs;
  assign obs = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord, extop, memreq,
                regdst, memtoreg, alusrcb, pcsrc, aluop, illegal, bus_err};

  int n_assert = 0;
  int n_fail = 0;
  step_t cur = T_F;
  step_t q[$];
  int wcnt = 0;
  ctl_t last;

  task automatic check(input logic [31:0] o, input logic [31:0] e, input string tag);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Instruction-level expectation: the sequence of control steps each opcode walks through after fetch.
  task automatic load_plan(input logic [5:0] o);
    q.push_back(T_D);
    case (o)
      OP_LW:          begin q.push_back(T_MA); q.push_back(T_MR); q.push_back(T_MWB); end
      OP_SW:          begin q.push_back(T_MA); q.push_back(T_MW); end
      OP_R:           begin q.push_back(T_EX); q.push_back(T_AWB); end
      OP_BEQ:         q.push_back(T_BR);
      OP_BNE:         q.push_back(T_BRN);
      OP_ADDI, OP_SLTI: begin q.push_back(T_IE); q.push_back(T_IWB); end
      OP_ANDI, OP_ORI:  begin q.push_back(T_LE); q.push_back(T_IWB); end
      OP_J:           q.push_back(T_J);
      OP_JAL:         q.push_back(T_JAL);
      default:        q.push_back(T_TRAP);
    endcase
  endtask

  function automatic ctl_t exp_ctl(input step_t s, input logic [5:0] o, input logic r);
    ctl_t c = '0;
    case (s)
      T_F:   begin c.memreq = 1; c.alusrcb = 2'b01; c.irwrite = r; c.pcwrite = r; end
      T_D:   c.alusrcb = 2'b11;
      T_MA:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      T_MR:  begin c.memreq = 1; c.iord = 1; end
      T_MWB: begin c.regwrite = 1; c.memtoreg = 2'b01; end
      T_MW:  begin c.memreq = 1; c.iord = 1; c.memwrite = r; end
      T_EX:  begin c.alusrca = 1; c.aluop = 3'b010; end
      T_AWB: begin c.regwrite = 1; c.regdst = 2'b01; end
      T_BR:  begin c.alusrca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branch = 1; end
      T_BRN: begin c.alusrca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branch = 1; c.bne = 1; end
      T_IE:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = (o == OP_SLTI) ? 3'b101 : 3'b000; end
      T_LE:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.extop = 1; c.aluop = (o == OP_ORI) ? 3'b100 : 3'b011; end
      T_IWB: c.regwrite = 1;
      T_J:   begin c.pcwrite = 1; c.pcsrc = 2'b10; end
      T_JAL: begin c.pcwrite = 1; c.pcsrc = 2'b10; c.regwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
      T_TRAP: c.illegal = 1;
      T_ERR:  c.bus_err = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] exp_state(input step_t s);
    case (s)
      T_F: return S_FETCH;     T_D: return S_DECODE;    T_MA: return S_MEMADR;
      T_MR: return S_MEMRD;    T_MWB: return S_MEMWB;   T_MW: return S_MEMWR;
      T_EX: return S_EXECUTE;  T_AWB: return S_ALUWB;   T_BR: return S_BRANCH;
      T_BRN: return S_BRANCHN; T_IE: return S_IMMEX;    T_LE: return S_LOGEX;
      T_IWB: return S_IMMWB;   T_J: return S_JUMP;      T_JAL: return S_JAL;
      T_TRAP: return S_TRAP;   default: return S_ERR;
    endcase
  endfunction

  task automatic model_reset();
    cur = T_F;
    q.delete();
    wcnt = 0;
  endtask

  task automatic advance(input logic [5:0] o, input logic r);
    if (cur != T_ERR) begin
      if ((cur == T_F || cur == T_MR || cur == T_MW) && !r) begin
        wcnt++;
        if (wcnt == TMO) cur = T_ERR;
      end else begin
        wcnt = 0;
        if (cur == T_F) load_plan(o);
        if (q.size() == 0) cur = T_F;
        else cur = q.pop_front();
      end
    end
  endtask

  task automatic step(input logic [5:0] o, input logic r);
    @(negedge clk);
    op = o;
    mem_ready = r;
    #1;
    last = obs;
    check(32'(obs), 32'(exp_ctl(cur, o, r)), $sformatf("ctl[%s]", cur.name()));
    check(32'(state), 32'(exp_state(cur)), $sformatf("state[%s]", cur.name()));
    advance(o, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    check(32'(state), 32'(S_FETCH), "reset_state");
    check(32'(obs), 32'(exp_ctl(T_F, 6'd0, 1'b0)), "reset_ctl");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [11] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI,
                             OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL};
    if ($urandom_range(0, 7) == 0) return 6'($urandom);
    return tbl[$urandom_range(0, 10)];
  endfunction

  initial begin
    int cyc, cnt, pos;
    ctl_t cap;
    logic [5:0] rop;
    logic rr;

    do_reset();

    // Reset during a stalled store: aborts immediately without a write strobe.
    step(OP_SW, 1); step(OP_SW, 1); step(OP_SW, 1); step(OP_SW, 0);
    #3 reset = 1'b1;
    #1;
    check(32'(state), 32'(S_FETCH), "midwr_state");
    check(32'(memwrite), 32'd0, "midwr_memwrite");
    check(32'(memreq), 32'd1, "midwr_memreq");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // LW with memory always ready.
    cyc = 0; cnt = 0;
    do begin step(OP_LW, 1); cyc++; cnt += int'(last.regwrite); end while (cur != T_F && cyc < 20);
    check(32'(cyc), 32'd5, "lw_cycles");
    check(32'(cnt), 32'd1, "lw_regwrite_count");

    // SW with three stalled MEMWR cycles.
    step(OP_SW, 1); step(OP_SW, 1); step(OP_SW, 1);
    cnt = 0; pos = 0;
    for (int i = 1; i <= 4; i++) begin
      step(OP_SW, (i == 4));
      if (last.memwrite) begin cnt++; pos = i; end
    end
    check(32'(cnt), 32'd1, "sw_memwrite_pulses");
    check(32'(pos), 32'd4, "sw_memwrite_cycle");

    // JAL completes in three cycles.
    cyc = 0;
    do begin step(OP_JAL, 1); cyc++; if (cyc == 3) cap = last; end while (cur != T_F && cyc < 20);
    check(32'(cyc), 32'd3, "jal_cycles");
    check({cap.pcwrite, cap.pcsrc, cap.regdst, cap.memtoreg, cap.regwrite},
          {1'b1, 2'b10, 2'b10, 2'b10, 1'b1}, "jal_ctl");

    // Illegal opcode traps for one cycle and returns to fetch.
    cyc = 0; cnt = 0;
    do begin step(6'b111111, 1); cyc++; cnt += int'(last.illegal); end while (cur != T_F && cyc < 20);
    check(32'(cyc), 32'd3, "trap_cycles");
    check(32'(cnt), 32'd1, "illegal_pulses");

    // BNE drives branch and bne with subtract.
    step(OP_BNE, 1); step(OP_BNE, 1); step(OP_BNE, 1);
    check({last.branch, last.bne, last.aluop}, {1'b1, 1'b1, 3'b001}, "bne_ctl");

    // Fetch never completes: bus error after the timeout, sticky until reset.
    for (int i = 0; i < TMO; i++) step(OP_LW, 0);
    check(32'(state), 32'(S_FETCH), "tmo_still_fetch");
    step(OP_LW, 1); step(OP_LW, 1); step(OP_LW, 0);
    check(32'(last.bus_err), 32'd1, "bus_err_sticky");
    do_reset();

    // Random instruction streams with random memory stalls.
    for (int i = 0; i < 3000; i++) begin
      if (cur == T_F) rop = pick_op();
      rr = ($urandom_range(0, 3) != 0);
      step(rop, rr);
      if (cur == T_ERR) begin
        step(rop, 1);
        step(rop, 0);
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
